// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a round-robin
// multiplexed 7-segment display scanner that shares one external decoder.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            bcd_out,
    input  logic [6:0]            segments_in,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int WORK_W = BCD_W + BIN_WIDTH;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    overflow_q;
    logic [WORK_W-1:0]       work_q;
    logic [WORK_W-1:0]       work_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [BCD_W-1:0]        disp_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        bcd_idx_q;
    logic [PRE_W-1:0]        presc_q;
    logic [3:0]              bcd_q;
    logic [3:0]              bcd_d;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   den_q;
    logic [NUM_DIGITS-1:0]   den_d;
    logic [BCD_W-1:0]        adj;
    logic [3:0]              disp_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_mask;

    // Per-nibble add-3 correction ahead of the shift; blank mask marks digits
    // whose own nibble and every higher nibble are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign adj[4*gi +: 4] = (work_q[BIN_WIDTH + 4*gi +: 4] >= 4'd5)
                              ? work_q[BIN_WIDTH + 4*gi +: 4] + 4'd3
                              : work_q[BIN_WIDTH + 4*gi +: 4];
        assign disp_nib[gi]   = disp_q[4*gi +: 4];
        assign blank_mask[gi] = (gi != 0) && (disp_q[BCD_W-1:4*gi] == '0);
    end

    assign work_d = {adj, work_q[BIN_WIDTH-1:0]} << 1;

    always_comb begin
        bcd_d = (blank_lz && blank_mask[idx_q]) ? 4'hF : disp_nib[idx_q];
        den_d = NUM_DIGITS'(1) << bcd_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            work_q     <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q    <= CONVERT;
                        work_q     <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        overflow_q <= (64'(bin_in) > MAX_VAL);
                    end
                end
                CONVERT: begin
                    work_q <= work_d;
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        disp_q  <= overflow_q ? ALL_NINES : work_d[WORK_W-1 -: BCD_W];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan runs free of the converter; digit_en lags bcd_out by one cycle so
    // it lines up with the registered decoder result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            bcd_idx_q <= '0;
            bcd_q     <= 4'd0;
            seg_q     <= 7'b0;
            den_q     <= '0;
        end else begin
            if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            bcd_q     <= bcd_d;
            bcd_idx_q <= idx_q;
            seg_q     <= segments_in;
            den_q     <= den_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;
    assign seg_out  = seg_q;
    assign digit_en = den_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle,
// plus directed literal checks of conversion, blanking, overflow and scan timing.
module tb_seven_seg_scan_ctrl;

    localparam int ND   = 4;
    localparam int BW   = 14;
    localparam int RD   = 4;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic [BW-1:0] bin_in = '0;
    logic          blank_lz = 1'b0;
    logic          busy, overflow;
    logic [3:0]    bcd_out;
    logic [6:0]    segments_in, seg_out;
    logic [ND-1:0] digit_en;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in), .blank_lz(blank_lz),
        .busy(busy), .overflow(overflow), .bcd_out(bcd_out), .segments_in(segments_in),
        .seg_out(seg_out), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    assign segments_in = dec(bcd_out);

    function automatic int p10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: display held as a decimal value, scan slot from cycle count.
    int            m_n = 0, m_disp = 0, m_pend = 0, m_rem = 0, m_prev_idx = 0;
    bit            m_busy = 0, m_ovf = 0;
    logic [3:0]    m_bcd = 4'd0;
    logic [6:0]    m_seg = 7'd0;
    logic [ND-1:0] m_den = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_disp <= 0; m_pend <= 0; m_rem <= 0; m_prev_idx <= 0;
            m_busy <= 0; m_ovf <= 0; m_bcd <= 4'd0; m_seg <= 7'd0; m_den <= '0;
        end else begin
            int idx, dig;
            bit ovf_now;
            idx = (m_n / RD) % ND;
            dig = (m_disp / p10(idx)) % 10;
            m_bcd <= (blank_lz && idx != 0 && m_disp < p10(idx)) ? 4'hF : 4'(dig);
            m_seg <= dec(m_bcd);
            m_den <= ND'(1) << m_prev_idx;
            m_prev_idx <= idx;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 0;
                    m_disp <= m_pend;
                end
            end else if (load) begin
                ovf_now = (int'(bin_in) > MAXV);
                m_busy <= 1;
                m_rem  <= BW;
                m_ovf  <= ovf_now;
                m_pend <= ovf_now ? MAXV : int'(bin_in);
            end
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ovf);
        check("bcd_out", bcd_out, m_bcd);
        check("seg_out", seg_out, m_seg);
        check("digit_en", digit_en, m_den);
    end

    task automatic load_wait(input int v, input int pulse_at, input int v2, output int cyc);
        @(negedge clk);
        load = 1'b1; bin_in = BW'(v);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            load = (i == pulse_at);
            if (i == pulse_at) bin_in = BW'(v2);
            if (busy) cyc++;
            else break;
        end
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_digit(input string name, input int d, input logic [6:0] exp);
        bit found = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (digit_en == ND'(1 << d)) begin found = 1; break; end
        end
        if (!found) check({name, "_timeout"}, digit_en, ND'(1 << d));
        else        check(name, seg_out, exp);
    endtask

    initial begin
        int cyc, held;
        bit found;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_den", digit_en, 0);
        check("rst_seg", seg_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_den", digit_en, 4'b0001);
        check("first_seg", seg_out, 7'b1111110);

        load_wait(1234, 0, 0, cyc);
        check("busy_len_1234", cyc, 14);
        check_digit("d0_1234", 0, 7'b0110011);
        check_digit("d1_1234", 1, 7'b1111001);
        check_digit("d2_1234", 2, 7'b1101101);
        check_digit("d3_1234", 3, 7'b0110000);

        @(negedge clk) blank_lz = 1'b1;
        load_wait(7, 0, 0, cyc);
        check_digit("d0_7", 0, 7'b1110000);
        check_digit("d1_7_blank", 1, 7'b0000000);
        check_digit("d3_7_blank", 3, 7'b0000000);

        load_wait(12000, 0, 0, cyc);
        check("ovf_set", overflow, 1);
        check_digit("d0_ovf", 0, 7'b1110011);
        check_digit("d3_ovf", 3, 7'b1110011);

        @(negedge clk) blank_lz = 1'b0;
        load_wait(42, 0, 0, cyc);
        check("ovf_clr", overflow, 0);
        check_digit("d0_42", 0, 7'b1101101);
        check_digit("d1_42", 1, 7'b0110011);
        check_digit("d3_42", 3, 7'b1111110);

        load_wait(1234, 2, 55, cyc);
        check("busy_len_drop", cyc, 14);
        check_digit("d0_drop", 0, 7'b0110011);
        check_digit("d1_drop", 1, 7'b1111001);

        // Slot length and wrap from the last digit back to digit 0.
        check_digit("d3_pre_wrap", 3, 7'b0110000);
        found = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (digit_en != 4'b1000) begin found = 1; break; end
        end
        check("wrap_den", digit_en, 4'b0001);
        held = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (digit_en == 4'b0001) held++;
            else break;
        end
        check("slot_hold", held, RD);

        // Reset in the middle of a conversion.
        @(negedge clk); load = 1'b1; bin_in = BW'(1234);
        @(negedge clk); load = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_den", digit_en, 0);
        check("midrst_seg", seg_out, 0);
        check("midrst_bcd", bcd_out, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_first_den", digit_en, 4'b0001);
        repeat (30) @(negedge clk);
        check("midrst_busy_after", busy, 0);
        check_digit("midrst_d3_zero", 3, 7'b1111110);

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: bin_in = BW'($urandom_range(0, 99));
                1: bin_in = BW'($urandom_range(0, 9999));
                2: bin_in = BW'($urandom_range(10000, 16383));
                default: bin_in = BW'($urandom_range(0, 16383));
            endcase
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
        end
        load = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Sequencer that owns the shared BCD-to-7-segment decoder and time-multiplexes it across a multi-digit common-anode/cathode display. It accepts a binary value, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and holds the result in a display register. It then scans digits round-robin, driving one BCD nibble per slot into the decoder and enabling the matching digit. It sits between the CPU output register and the display pins.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8)
BIN_WIDTH, 14, width of binary input value
REFRESH_DIV, 1000, clk cycles each digit stays active (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  single-cycle request to convert and display bin_in
bin_in  input  BIN_WIDTH  binary value, sampled when load accepted
blank_lz  input  1  1 = blank leading zeros (digit 0 never blanked)
busy  output  1  conversion in progress; load ignored while high
overflow  output  1  last accepted value exceeded 10^NUM_DIGITS-1
bcd_out  output  4  nibble to shared decoder; 4'hF = blank (decoder outputs all-off)
segments_in  input  7  decoder result, ABCDEFG, bit6 = A, 1 = segment on
seg_out  output  7  registered segment pins
digit_en  output  NUM_DIGITS  one-hot active-high digit select, aligned with seg_out

Behaviour:
- Reset is asynchronous on rst_n low. All of the following are forced: FSM IDLE, busy 0, overflow 0, display register all 0, digit index 0, prescaler 0, bcd_out 4'd0, seg_out 7'b0, digit_en all 0.
- FSM states: IDLE, CONVERT.
  - IDLE -> CONVERT on load=1. On that edge: capture bin_in, clear the shift register, busy<=1.
  - Overflow is evaluated at capture. If bin_in > 10^NUM_DIGITS-1, the engine is bypassed and all display nibbles are set to 9 when the conversion finishes. overflow<=1; otherwise overflow<=0.
- CONVERT runs exactly BIN_WIDTH cycles. Each cycle:
  - every BCD nibble >= 5 gets +3;
  - then the combined {bcd, bin} register shifts left by 1.
  - Working register width is 4*NUM_DIGITS + BIN_WIDTH.
- Completion: on the edge ending the BIN_WIDTH-th cycle, the display register is written atomically and busy<=0.
  - Load accepted at edge k → busy high from k to k+BIN_WIDTH; display updated at edge k+BIN_WIDTH.
- load while busy=1 is dropped (no queue). load in the same cycle busy falls is dropped as well. Software polls busy.
- Scan prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index increments modulo NUM_DIGITS (index NUM_DIGITS-1 -> 0).
- Every cycle, bcd_out <= display[index], or 4'hF if blanked.
  - A digit is blanked when blank_lz=1, index != 0, and it and all higher digits are zero.
  - blank_lz is sampled combinationally each cycle.
- Every cycle:
  - seg_out <= segments_in (decoder is combinational on bcd_out);
  - digit_en <= one-hot of the index that produced the current bcd_out.
  - Net effect: seg_out and digit_en change on the same edge, 1 cycle after bcd_out. No ghosting.
- First active edge after reset release: digit_en=...0001 with seg_out = decoder(0) = 7'b1111110.
- A display update during a digit's slot is visible on the next bcd_out sample. Scan timing is unaffected by conversions.
- Reset mid-conversion aborts it. The display returns to 0 and the scan restarts at digit 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs at reset values immediately; after release, first edge shows digit_en=0001, seg_out=1111110.
- load=1, bin_in=1234, blank_lz=0 -> busy high 14 cycles, then digits 0..3 scan nibbles 4,3,2,1; seg_out=0110011, 1111001, 1101101, 0110000 with digit_en 0001, 0010, 0100, 1000.
- blank_lz=1, bin_in=7 -> digit0 seg_out=1110000; digits 1..3 bcd_out=F, seg_out=0000000.
- bin_in=12000 -> overflow=1, all digits 9 (1110011); next load of 42 -> overflow=0, digits 2,4,0,0.
- Pulse load of 55 two cycles after load of 1234 -> second request ignored; display ends at 1234, busy duration unchanged.
- With REFRESH_DIV=4: verify each digit_en bit is held exactly 4 cycles, wrap 1000->0001; pull rst_n low during CONVERT -> display 0, busy 0, scan restarts at digit 0.
